btb_assoc_param: RTL

//  Parametrised set-associative branch target buffer for the fetch stage.

---
 rtl/btb_assoc_param.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/btb_assoc_param.sv
// btb_assoc_param: set-associative BTB with tree-PLRU replacement and flush sequencer.
// Define BTB_STATS_EN to build the lookup/hit/mispredict statistics counters.
module btb_assoc_param #(
   parameter int SETS      = 4,
   parameter int WAYS      = 4,
   parameter int ADDR_W    = 16,
   parameter int INDEX_LSB = 1,
   parameter int CTR_W     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              lookup_valid,
   input  logic [ADDR_W-1:0] lookup_pc,
   output logic              pred_valid,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_valid,
   output logic              upd_ready,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_taken,
   input  logic              flush,
   output logic              flush_busy,
   output logic [31:0]       stat_lookups,
   output logic [31:0]       stat_hits,
   output logic [31:0]       stat_mispred
);
   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);
   localparam int PL_W  = WAYS - 1;
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
   logic [SETS-1:0][WAYS-1:0][ADDR_W-1:0] tag_q, tag_d;
   logic [SETS-1:0][WAYS-1:0][ADDR_W-1:0] tgt_q, tgt_d;
   logic [SETS-1:0][WAYS-1:0][CTR_W-1:0] ctr_q, ctr_d;
   logic [SETS-1:0][PL_W-1:0] plru_q, plru_d;
   logic pv_q, pv_d, ph_q, ph_d, pt_q, pt_d;
   logic [ADDR_W-1:0] ptgt_q, ptgt_d;

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [WAY_W-1:0] lk_way, up_way, inv_way, al_way;
   logic lk_hit, up_hit, inv_found, upd_fire;
   logic [CTR_W-1:0] up_ctr;

   // Level l of the tree is steered by way bit l; a bit value of 1 points at ways with that bit set.
   function automatic logic [PL_W-1:0] touch(input logic [PL_W-1:0] row,
                                             input logic [WAY_W-1:0] w);
      logic [PL_W-1:0] r;
      logic [WAY_W-1:0] nd;
      r = row;
      for (int l = 0; l < WAY_W; l++) begin
         nd = WAY_W'((1 << l) - 1 + (int'(w) & ((1 << l) - 1)));
         r[nd] = ~w[l];
      end
      return r;
   endfunction

   function automatic logic [WAY_W-1:0] victim(input logic [PL_W-1:0] row);
      logic [WAY_W-1:0] w;
      logic [WAY_W-1:0] nd;
      w = '0;
      for (int l = 0; l < WAY_W; l++) begin
         nd = WAY_W'((1 << l) - 1 + (int'(w) & ((1 << l) - 1)));
         w[l] = row[nd];
      end
      return w;
   endfunction

   assign upd_ready  = (state_q == IDLE) & ~flush;
   assign flush_busy = (state_q == FLUSH);
   assign upd_fire   = upd_valid & upd_ready;
   assign pred_valid  = pv_q;
   assign pred_hit    = ph_q;
   assign pred_taken  = pt_q;
   assign pred_target = ptgt_q;

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      ctr_d   = ctr_q;
      plru_d  = plru_q;
      state_d = state_q;
      cnt_d   = cnt_q;

      lk_idx = lookup_pc[INDEX_LSB +: IDX_W];
      lk_hit = 1'b0;
      lk_way = '0;
      up_idx = upd_pc[INDEX_LSB +: IDX_W];
      up_hit = 1'b0;
      up_way = '0;
      inv_found = 1'b0;
      inv_way = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (valid_q[lk_idx][i] && tag_q[lk_idx][i] == lookup_pc) begin
            lk_hit = 1'b1;
            lk_way = WAY_W'(i);
         end
         if (valid_q[up_idx][i] && tag_q[up_idx][i] == upd_pc) begin
            up_hit = 1'b1;
            up_way = WAY_W'(i);
         end
         if (!valid_q[up_idx][i]) begin
            inv_found = 1'b1;
            inv_way = WAY_W'(i);
         end
      end

      pv_d   = lookup_valid;
      ph_d   = lookup_valid & lk_hit & (state_q == IDLE);
      pt_d   = ph_d & ctr_q[lk_idx][lk_way][CTR_W-1];
      ptgt_d = ph_d ? tgt_q[lk_idx][lk_way] : '0;
      if (ph_d) plru_d[lk_idx] = touch(plru_q[lk_idx], lk_way);

      up_ctr = ctr_q[up_idx][up_way];
      al_way = inv_found ? inv_way : victim(plru_q[up_idx]);
      // Update PLRU is computed from pre-edge state and overrides any lookup touch.
      if (upd_fire && up_hit) begin
         if (upd_taken) begin
            if (up_ctr != CTR_MAX) ctr_d[up_idx][up_way] = up_ctr + 1'b1;
            tgt_d[up_idx][up_way] = upd_target;
         end else if (up_ctr != '0) begin
            ctr_d[up_idx][up_way] = up_ctr - 1'b1;
         end
         plru_d[up_idx] = touch(plru_q[up_idx], up_way);
      end else if (upd_fire && upd_taken) begin
         valid_d[up_idx][al_way] = 1'b1;
         tag_d[up_idx][al_way]   = upd_pc;
         tgt_d[up_idx][al_way]   = upd_target;
         ctr_d[up_idx][al_way]   = CTR_INIT;
         plru_d[up_idx] = touch(plru_q[up_idx], al_way);
      end

      unique case (state_q)
         IDLE: begin
            if (flush) begin
               state_d = FLUSH;
               cnt_d = '0;
            end
         end
         FLUSH: begin
            valid_d[cnt_q] = '0;
            plru_d[cnt_q] = '0;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(SETS - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= '0;
         tag_q   <= '0;
         tgt_q   <= '0;
         ctr_q   <= '0;
         plru_q  <= '0;
         pv_q    <= 1'b0;
         ph_q    <= 1'b0;
         pt_q    <= 1'b0;
         ptgt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
         tgt_q   <= tgt_d;
         ctr_q   <= ctr_d;
         plru_q  <= plru_d;
         pv_q    <= pv_d;
         ph_q    <= ph_d;
         pt_q    <= pt_d;
         ptgt_q  <= ptgt_d;
      end
   end

`ifdef BTB_STATS_EN
   logic [31:0] st_lk_q, st_lk_d, st_hit_q, st_hit_d, st_mis_q, st_mis_d;
   logic mispred;

   // A miss is treated as a not-taken prediction.
   assign mispred = upd_fire & ((up_hit & up_ctr[CTR_W-1]) != upd_taken);

   always_comb begin
      st_lk_d  = st_lk_q;
      st_hit_d = st_hit_q;
      st_mis_d = st_mis_q;
      if (lookup_valid && st_lk_q != '1) st_lk_d = st_lk_q + 32'd1;
      if (ph_d && st_hit_q != '1) st_hit_d = st_hit_q + 32'd1;
      if (mispred && st_mis_q != '1) st_mis_d = st_mis_q + 32'd1;
      if (state_q == IDLE && flush) begin
         st_lk_d  = '0;
         st_hit_d = '0;
         st_mis_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_lk_q  <= '0;
         st_hit_q <= '0;
         st_mis_q <= '0;
      end else begin
         st_lk_q  <= st_lk_d;
         st_hit_q <= st_hit_d;
         st_mis_q <= st_mis_d;
      end
   end

   assign stat_lookups = st_lk_q;
   assign stat_hits    = st_hit_q;
   assign stat_mispred = st_mis_q;
`else
   assign stat_lookups = '0;
   assign stat_hits    = '0;
   assign stat_mispred = '0;
`endif
endmodule
